// File: rtl/pio.sv
// pio: four-state-machine programmable I/O block with shared instruction memory and GPIO bank
//  clk          system clock, all state on posedge
//  reset        asynchronous active-low reset
//  action/index/mindex/din   one-cycle host command bus
//  dout         RX word popped by the last host PULL
//  gpio_in      pad inputs; gpio_out/gpio_dir pad values and directions (1 = output)
//  tx_full      per-SM TX FIFO full; rx_empty per-SM RX FIFO empty
module pio #(
  parameter int NSM  = 4,
  parameter int FDEP = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     action,
  input  logic [4:0]     index,
  input  logic [1:0]     mindex,
  input  logic [31:0]    din,
  output logic [31:0]    dout,
  input  logic [31:0]    gpio_in,
  output logic [31:0]    gpio_out,
  output logic [31:0]    gpio_dir,
  output logic [NSM-1:0] tx_full,
  output logic [NSM-1:0] rx_empty
);
  localparam int AW = $clog2(FDEP);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FDEP);
  localparam logic [2:0] OP_JMP = 3'b000;
  localparam logic [2:0] OP_PP  = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_SET = 3'b111;
  typedef enum logic [3:0] {
    A_NONE, A_INSTR, A_PEND, A_PULL, A_PUSH, A_GRPS, A_EN, A_DIV,
    A_SIDES, A_IMM, A_SHIFT, A_IPINS, A_IDIRS
  } act_t;
  logic [15:0] r_imem [32];
  logic [31:0] r_gout, r_gdir, r_dout, w_gout, w_gdir;
  logic [NSM-1:0] r_en, w_hpok;
  logic [NSM-1:0][31:0] w_pm, w_pv, w_dm, w_dv, w_rxh;
  always_ff @(posedge clk)
    if (action == A_INSTR) r_imem[index] <= din[15:0];
  for (genvar g = 0; g < NSM; g++) begin : g_sm
    logic [23:0] r_acc, r_div, w_deff;
    logic [24:0] w_sum;
    logic [4:0] r_pc, r_dly, r_wtop, r_wbot, r_sbase, w_npc, w_ndly, w_seq;
    logic [2:0] r_scnt;
    logic [31:0] r_x, r_y, r_isr, r_osr, w_nx, w_ny, w_nisr, w_nosr;
    logic r_osrf, w_nosrf, r_immv;
    logic [15:0] r_imm, w_ins;
    logic [31:0] r_txm [FDEP];
    logic [31:0] r_rxm [FDEP];
    logic [AW-1:0] r_txr, r_rxr;
    logic [CW-1:0] r_txc, r_rxc;
    logic w_sel, w_hpush, w_hpull, w_tpush, w_rpop, w_pop, w_push;
    logic w_dtick, w_tick, w_exec, w_stall, w_done, w_jmp, w_txe, w_rxf;
    logic [7:0] w_cv;
    logic [31:0] w_txh, w_src0, w_src, w_smask, w_sval, w_lpm, w_lpv, w_ldm, w_ldv;
    assign w_sel   = mindex == 2'(g);
    assign w_hpush = action == A_PUSH && w_sel;
    assign w_hpull = action == A_PULL && w_sel;
    assign w_txe   = r_txc == '0;
    assign w_rxf   = r_rxc == FULL;
    // a host push into a full TX is still accepted when the SM pops the same cycle
    assign w_tpush = w_hpush && (!w_rxf_tx() || w_pop);
    assign w_rpop  = w_hpull && r_rxc != '0;
    assign w_txh   = r_txm[r_txr];
    assign w_sum   = {1'b0, r_acc} + 25'h100;
    assign w_deff  = r_div[23:8] == '0 ? {16'd1, r_div[7:0]} : r_div;
    assign w_dtick = r_en[g] && w_sum >= {1'b0, w_deff};
    // a disabled SM still runs a pending IMM, one step per clock
    assign w_tick  = r_en[g] ? w_dtick : r_immv;
    assign w_exec  = w_tick && r_dly == '0;
    assign w_ins   = r_immv ? r_imm : r_imem[r_pc];
    assign w_seq   = r_pc == r_wtop ? r_wbot : r_pc + 5'd1;
    assign w_stall = w_ins[15:13] == OP_PP && w_ins[5] && (w_ins[7] ? w_txe : w_rxf);
    assign w_done  = w_exec && !w_stall;
    assign w_cv    = {r_osrf, gpio_in[r_sbase], r_x != r_y, r_y != '0, r_y == '0, r_x != '0, r_x == '0, 1'b1};
    assign w_jmp   = w_cv[w_ins[7:5]];
    assign w_src0  = w_ins[2:0] == 3'd0 ? gpio_in :
                     w_ins[2:0] == 3'd1 ? r_x :
                     w_ins[2:0] == 3'd2 ? r_y :
                     w_ins[2:0] == 3'd6 ? r_isr :
                     w_ins[2:0] == 3'd7 ? r_osr : '0;
    assign w_src   = w_ins[4:3] == 2'b01 ? ~w_src0 : w_src0;
    function automatic logic w_rxf_tx();
      return r_txc == FULL;
    endfunction
    always_comb begin
      w_smask = '0;
      w_sval  = '0;
      for (int i = 0; i < 5; i++) begin
        w_smask[r_sbase + 5'(i)] = 3'(i) < r_scnt;
        w_sval[r_sbase + 5'(i)]  = w_ins[i];
      end
    end
    always_comb begin
      w_npc   = r_pc;
      w_ndly  = r_dly;
      w_nx    = r_x;
      w_ny    = r_y;
      w_nisr  = r_isr;
      w_nosr  = r_osr;
      w_nosrf = r_osrf;
      w_pop   = 1'b0;
      w_push  = 1'b0;
      w_lpm   = '0;
      w_lpv   = '0;
      w_ldm   = '0;
      w_ldv   = '0;
      if (w_tick && r_dly != '0) w_ndly = r_dly - 5'd1;
      else if (w_done) begin
        w_ndly = w_ins[12:8];
        w_npc  = r_immv ? r_pc : w_seq;
        case (w_ins[15:13])
          OP_JMP: begin
            w_nx  = w_ins[7:5] == 3'd2 ? r_x - 32'd1 : r_x;
            w_ny  = w_ins[7:5] == 3'd4 ? r_y - 32'd1 : r_y;
            w_npc = w_jmp ? w_ins[4:0] : w_npc;
          end
          OP_PP: begin
            w_pop   = w_ins[7] && !w_txe;
            w_nosr  = w_ins[7] ? (w_txe ? r_x : w_txh) : r_osr;
            w_nosrf = w_ins[7] ? 1'b1 : r_osrf;
            w_push  = !w_ins[7] && !w_rxf;
            w_nisr  = w_ins[7] ? r_isr : '0;
          end
          OP_MOV: begin
            w_nx    = w_ins[7:5] == 3'd1 ? w_src : r_x;
            w_ny    = w_ins[7:5] == 3'd2 ? w_src : r_y;
            w_nisr  = w_ins[7:5] == 3'd6 ? w_src : r_isr;
            w_nosr  = w_ins[7:5] == 3'd7 ? w_src : r_osr;
            w_nosrf = w_ins[7:5] == 3'd7 ? 1'b1 : r_osrf;
          end
          OP_SET: begin
            w_nx  = w_ins[7:5] == 3'd1 ? {27'd0, w_ins[4:0]} : r_x;
            w_ny  = w_ins[7:5] == 3'd2 ? {27'd0, w_ins[4:0]} : r_y;
            w_lpm = w_ins[7:5] == 3'd0 ? w_smask : '0;
            w_lpv = w_sval;
            w_ldm = w_ins[7:5] == 3'd4 ? w_smask : '0;
            w_ldv = w_sval;
          end
          default: ;
        endcase
      end
    end
    always_ff @(posedge clk) begin
      if (w_tpush) r_txm[r_txr + r_txc[AW-1:0]] <= din;
      if (w_push) r_rxm[r_rxr + r_rxc[AW-1:0]] <= r_isr;
    end
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        r_acc   <= '0;
        r_div   <= 24'h000100;
        r_pc    <= '0;
        r_dly   <= '0;
        r_wtop  <= 5'd31;
        r_wbot  <= '0;
        r_sbase <= '0;
        r_scnt  <= '0;
        r_x     <= '0;
        r_y     <= '0;
        r_isr   <= '0;
        r_osr   <= '0;
        r_osrf  <= 1'b0;
        r_immv  <= 1'b0;
        r_imm   <= '0;
        r_txr   <= '0;
        r_rxr   <= '0;
        r_txc   <= '0;
        r_rxc   <= '0;
      end else begin
        r_pc    <= w_npc;
        r_dly   <= w_ndly;
        r_x     <= w_nx;
        r_y     <= w_ny;
        r_isr   <= w_nisr;
        r_osr   <= w_nosr;
        r_osrf  <= w_nosrf;
        r_immv  <= action == A_IMM && w_sel ? 1'b1 : w_done ? 1'b0 : r_immv;
        r_imm   <= action == A_IMM && w_sel ? din[15:0] : r_imm;
        r_wtop  <= action == A_PEND && w_sel ? din[16:12] : r_wtop;
        r_wbot  <= action == A_PEND && w_sel ? din[11:7] : r_wbot;
        r_scnt  <= action == A_GRPS && w_sel ? din[28:26] : r_scnt;
        r_sbase <= action == A_GRPS && w_sel ? din[9:5] : r_sbase;
        r_div   <= action == A_DIV && w_sel ? din[23:0] : r_div;
        r_acc   <= action == A_EN && din[g] && !r_en[g] ? '0 :
                   w_dtick ? 24'(w_sum - {1'b0, w_deff}) :
                   r_en[g] ? w_sum[23:0] : r_acc;
        r_txr   <= r_txr + AW'(w_pop);
        r_txc   <= r_txc + CW'(w_tpush) - CW'(w_pop);
        r_rxr   <= r_rxr + AW'(w_rpop);
        r_rxc   <= r_rxc + CW'(w_push) - CW'(w_rpop);
      end
    assign w_pm[g]   = w_lpm;
    assign w_pv[g]   = w_lpv;
    assign w_dm[g]   = w_ldm;
    assign w_dv[g]   = w_ldv;
    assign w_rxh[g]  = r_rxm[r_rxr];
    assign w_hpok[g] = w_rpop;
    assign tx_full[g]  = r_txc == FULL;
    assign rx_empty[g] = r_rxc == '0;
  end
  // ascending merge so the highest-numbered SM wins a shared pin
  always_comb begin
    w_gout = r_gout;
    w_gdir = r_gdir;
    for (int i = 0; i < NSM; i++) begin
      w_gout = (w_gout & ~w_pm[i]) | (w_pv[i] & w_pm[i]);
      w_gdir = (w_gdir & ~w_dm[i]) | (w_dv[i] & w_dm[i]);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_gout <= '0;
      r_gdir <= '0;
      r_dout <= '0;
      r_en   <= '0;
    end else begin
      r_gout <= action == A_IPINS ? din : w_gout;
      r_gdir <= action == A_IDIRS ? din : w_gdir;
      r_dout <= action == A_PULL && w_hpok[mindex] ? w_rxh[mindex] : r_dout;
      r_en   <= action == A_EN ? din[NSM-1:0] : r_en;
    end
  assign dout     = r_dout;
  assign gpio_out = r_gout;
  assign gpio_dir = r_gdir;
endmodule

// File: tb/tb_pio.sv
// tb_pio: randomized self-checking bench for pio against a behavioural model
module tb_pio;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] action = '0;
  logic [4:0] index = '0;
  logic [1:0] mindex = '0;
  logic [31:0] din = '0;
  logic [31:0] gpio_in = '0;
  logic [31:0] dout, gpio_out, gpio_dir;
  logic [3:0] tx_full, rx_empty;
  int n_cmp = 0;
  int n_bad = 0;
  pio dut (
    .clk(clk), .reset(reset), .action(action), .index(index), .mindex(mindex),
    .din(din), .dout(dout), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_dir(gpio_dir), .tx_full(tx_full), .rx_empty(rx_empty)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic act(input logic [3:0] a, input logic [1:0] m, input logic [31:0] d, input logic [4:0] ix);
    action = a;
    mindex = m;
    din = d;
    index = ix;
    @(posedge clk);
    #1;
    action = 4'd0;
  endtask
  task automatic host(input logic [3:0] a, input logic [1:0] m, input logic [31:0] d);
    act(a, m, d, 5'd0);
  endtask
  task automatic prog(input int addr, input logic [15:0] w);
    act(4'd1, 2'd0, {16'h0, w}, addr[4:0]);
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc();
  endtask
  function automatic int deff(input logic [31:0] d);
    return d[23:8] == 16'd0 ? int'(d[23:0]) + 256 : int'(d[23:0]);
  endfunction
  task automatic test_reset;
    #12;
    n_cmp += 5;
    if (dout !== 32'h0) begin n_bad++; $display("FAIL reset dout=%h exp=0", dout); end
    if (gpio_out !== 32'h0) begin n_bad++; $display("FAIL reset gpio_out=%h exp=0", gpio_out); end
    if (gpio_dir !== 32'h0) begin n_bad++; $display("FAIL reset gpio_dir=%h exp=0", gpio_dir); end
    if (tx_full !== 4'h0) begin n_bad++; $display("FAIL reset tx_full=%h exp=0", tx_full); end
    if (rx_empty !== 4'hF) begin n_bad++; $display("FAIL reset rx_empty=%h exp=F", rx_empty); end
    @(negedge clk);
    reset = 1'b1;
    cyc();
  endtask
  // tick count after n clocks with an ideal fractional divider is floor(n*1.0/div)
  task automatic test_square(input logic [31:0] d, input int ncyc);
    logic [31:0] exp;
    do_reset();
    prog(0, 16'hE001);
    prog(1, 16'hE000);
    host(4'd2, 2'd0, 32'h1000);
    host(4'd5, 2'd0, 32'h0400_0000);
    host(4'd7, 2'd0, d);
    host(4'd6, 2'd0, 32'h1);
    for (int n = 1; n <= ncyc; n++) begin
      cyc();
      exp = {31'b0, 1'((n * 256 / deff(d)) % 2)};
      n_cmp++;
      if (gpio_out !== exp) begin
        n_bad++;
        $display("FAIL square div=%h n=%0d gpio_out=%h exp=%h", d, n, gpio_out, exp);
      end
    end
  endtask
  task automatic test_delay;
    int d1, d2, pos;
    logic [31:0] exp;
    d1 = $urandom_range(0, 5);
    d2 = $urandom_range(0, 5);
    do_reset();
    prog(0, 16'hE001 | 16'(d1 << 8));
    prog(1, 16'hE000 | 16'(d2 << 8));
    host(4'd2, 2'd0, 32'h1000);
    host(4'd5, 2'd0, 32'h0400_0000);
    host(4'd6, 2'd0, 32'h1);
    for (int n = 1; n <= 30; n++) begin
      cyc();
      pos = (n - 1) % (d1 + d2 + 2);
      exp = {31'b0, pos <= d1};
      n_cmp++;
      if (gpio_out !== exp) begin
        n_bad++;
        $display("FAIL delay d1=%0d d2=%0d n=%0d gpio_out=%h exp=%h", d1, d2, n, gpio_out, exp);
      end
    end
  endtask
  task automatic test_fifo_loop;
    logic [31:0] w;
    int t;
    do_reset();
    prog(0, 16'h80A0);
    prog(1, 16'hA0C7);
    prog(2, 16'h8020);
    host(4'd2, 2'd0, 32'h2000);
    host(4'd7, 2'd0, 32'h0100);
    host(4'd6, 2'd0, 32'h1);
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      host(4'd4, 2'd0, w);
      n_cmp++;
      if (rx_empty[0] !== 1'b1) begin n_bad++; $display("FAIL fifo_early rx_empty=%h exp=F", rx_empty); end
      t = 0;
      while (rx_empty[0] && t < 20) begin cyc(); t++; end
      n_cmp++;
      if (rx_empty[0] !== 1'b0) begin n_bad++; $display("FAIL fifo_fall rx_empty=%h exp=E after %0d cycles", rx_empty, t); end
      host(4'd3, 2'd0, 32'h0);
      n_cmp += 3;
      if (dout !== w) begin n_bad++; $display("FAIL fifo_dout dout=%h exp=%h", dout, w); end
      if (rx_empty !== 4'hF) begin n_bad++; $display("FAIL fifo_empty rx_empty=%h exp=F", rx_empty); end
      if (tx_full !== 4'h0) begin n_bad++; $display("FAIL fifo_full tx_full=%h exp=0", tx_full); end
    end
  endtask
  task automatic test_flags;
    logic [31:0] q[$];
    logic [31:0] w;
    do_reset();
    prog(0, 16'h80A0);
    prog(1, 16'hA0C7);
    prog(2, 16'h8020);
    for (int k = 0; k < 5; k++) begin
      w = $urandom;
      host(4'd4, 2'd1, w);
      if (q.size() < 4) q.push_back(w);
      n_cmp += 2;
      if (tx_full !== (q.size() == 4 ? 4'b0010 : 4'b0000)) begin
        n_bad++;
        $display("FAIL flags_full k=%0d tx_full=%h exp=%h", k, tx_full, q.size() == 4 ? 4'b0010 : 4'b0000);
      end
      if (rx_empty !== 4'hF) begin n_bad++; $display("FAIL flags_empty k=%0d rx_empty=%h exp=F", k, rx_empty); end
    end
    host(4'd2, 2'd1, 32'h2000);
    host(4'd6, 2'd0, 32'h2);
    repeat (40) cyc();
    n_cmp += 2;
    if (tx_full !== 4'h0) begin n_bad++; $display("FAIL flags_drain tx_full=%h exp=0", tx_full); end
    if (rx_empty !== 4'b1101) begin n_bad++; $display("FAIL flags_rx rx_empty=%h exp=D", rx_empty); end
    foreach (q[k]) begin
      host(4'd3, 2'd1, 32'h0);
      n_cmp++;
      if (dout !== q[k]) begin n_bad++; $display("FAIL flags_order k=%0d dout=%h exp=%h", k, dout, q[k]); end
    end
    host(4'd3, 2'd1, 32'h0);
    n_cmp += 2;
    if (dout !== q[3]) begin n_bad++; $display("FAIL flags_emptypull dout=%h exp=%h", dout, q[3]); end
    if (rx_empty !== 4'hF) begin n_bad++; $display("FAIL flags_final rx_empty=%h exp=F", rx_empty); end
  endtask
  task automatic test_loop;
    int c, rises, t;
    logic prev;
    c = $urandom_range(1, 6);
    do_reset();
    prog(0, 16'hE020 | 16'(c));
    prog(1, 16'hE001);
    prog(2, 16'hE000);
    prog(3, 16'h0041);
    prog(4, 16'hE002);
    prog(5, 16'h0005);
    host(4'd5, 2'd0, 32'h0800_0000);
    host(4'd6, 2'd0, 32'h1);
    rises = 0;
    prev = 1'b0;
    t = 0;
    while (gpio_out !== 32'h2 && t < 200) begin
      cyc();
      if (gpio_out[0] && !prev) rises++;
      prev = gpio_out[0];
      t++;
    end
    n_cmp += 2;
    if (gpio_out !== 32'h2) begin n_bad++; $display("FAIL loop_end gpio_out=%h exp=2", gpio_out); end
    if (rises !== c + 1) begin n_bad++; $display("FAIL loop_count x=%0d iterations=%0d exp=%0d", c, rises, c + 1); end
  endtask
  task automatic test_priority;
    logic v;
    v = 1'($urandom_range(0, 1));
    do_reset();
    prog(0, v ? 16'hE000 : 16'hE001);
    prog(1, 16'h0000);
    prog(8, v ? 16'hE001 : 16'hE000);
    prog(9, 16'h0008);
    host(4'd5, 2'd0, 32'h0400_0000);
    host(4'd5, 2'd1, 32'h0400_0000);
    host(4'd9, 2'd1, 32'h0008);
    host(4'd6, 2'd0, 32'h3);
    for (int n = 1; n <= 8; n++) begin
      cyc();
      n_cmp++;
      if (gpio_out !== {31'b0, v}) begin
        n_bad++;
        $display("FAIL priority n=%0d gpio_out=%h exp=%h", n, gpio_out, {31'b0, v});
      end
    end
  endtask
  task automatic test_imm_reset;
    logic [31:0] dirs, v;
    int b;
    logic [1:0] m;
    do_reset();
    prog(0, 16'hE001);
    prog(1, 16'hE000);
    host(4'd2, 2'd0, 32'h1000);
    host(4'd5, 2'd0, 32'h0400_0000);
    host(4'd6, 2'd0, 32'h1);
    dirs = $urandom | 32'h1;
    host(4'd12, 2'd0, dirs);
    for (int k = 0; k < 4; k++) host(4'd4, 2'd3, $urandom);
    n_cmp += 2;
    if (tx_full !== 4'b1000) begin n_bad++; $display("FAIL pre_reset tx_full=%h exp=8", tx_full); end
    if (gpio_dir !== dirs) begin n_bad++; $display("FAIL idirs gpio_dir=%h exp=%h", gpio_dir, dirs); end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp += 5;
    if (gpio_out !== 32'h0) begin n_bad++; $display("FAIL async gpio_out=%h exp=0", gpio_out); end
    if (gpio_dir !== 32'h0) begin n_bad++; $display("FAIL async gpio_dir=%h exp=0", gpio_dir); end
    if (dout !== 32'h0) begin n_bad++; $display("FAIL async dout=%h exp=0", dout); end
    if (tx_full !== 4'h0) begin n_bad++; $display("FAIL async tx_full=%h exp=0", tx_full); end
    if (rx_empty !== 4'hF) begin n_bad++; $display("FAIL async rx_empty=%h exp=F", rx_empty); end
    @(negedge clk);
    reset = 1'b1;
    cyc();
    prog(0, 16'hE000);
    b = $urandom_range(0, 31);
    m = 2'($urandom_range(0, 3));
    host(4'd5, m, 32'h0400_0000 | 32'(b << 5));
    host(4'd9, m, 32'hE001);
    cyc();
    n_cmp++;
    if (gpio_out !== 32'h1 << b) begin n_bad++; $display("FAIL imm_set sm=%0d gpio_out=%h exp=%h", m, gpio_out, 32'h1 << b); end
    repeat (3) cyc();
    n_cmp++;
    if (gpio_out !== 32'h1 << b) begin n_bad++; $display("FAIL imm_hold gpio_out=%h exp=%h", gpio_out, 32'h1 << b); end
    host(4'd9, m, 32'hE081);
    cyc();
    n_cmp++;
    if (gpio_dir !== 32'h1 << b) begin n_bad++; $display("FAIL imm_dirs gpio_dir=%h exp=%h", gpio_dir, 32'h1 << b); end
    v = $urandom | (32'h1 << b);
    host(4'd9, m, 32'hE000);
    host(4'd11, m, v);
    n_cmp++;
    if (gpio_out !== v) begin n_bad++; $display("FAIL ipins_override gpio_out=%h exp=%h", gpio_out, v); end
  endtask
  initial begin
    gpio_in = $urandom;
    test_reset();
    test_square(32'h0280, 30);
    test_square(32'h0100, 20);
    test_square(32'h0080, 20);
    test_square(32'($urandom_range(32'h100, 32'h500)), 40);
    test_delay();
    test_fifo_loop();
    test_flags();
    test_loop();
    test_priority();
    test_imm_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
